// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory read, a one-entry output
// buffer toward IF/ID, redirect/flush handling and HALT detection.
module fetch_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic [15:0] instr_out,
    output logic [15:0] pc_plus2_out,
    output logic        valid_out,
    output logic        halted_out
);

    localparam logic [1:0]  S_IDLE   = 2'd0;
    localparam logic [1:0]  S_BUSY   = 2'd1;
    localparam logic [1:0]  S_SQUASH = 2'd2;
    localparam logic [1:0]  S_HALT   = 2'd3;

    localparam logic [15:0] NOP_WORD = 16'h0800;
    localparam logic [4:0]  HALT_OP  = 5'b00000;

    logic [1:0]  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] squash_addr_q, squash_addr_d;
    logic [15:0] buf_instr_q, buf_instr_d;
    logic [15:0] buf_pc2_q, buf_pc2_d;
    logic        buf_valid_q, buf_valid_d;

    logic        consume;
    logic        can_accept;
    logic [15:0] pc_next_seq;

    assign consume     = buf_valid_q & ~stall;
    assign can_accept  = ~buf_valid_q | consume;
    assign pc_next_seq = pc_q + 16'd2;

    // NOTE: every signal assigned here gets a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch to hold the old value.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        squash_addr_d = squash_addr_q;
        buf_instr_d   = buf_instr_q;
        buf_pc2_d     = buf_pc2_q;
        buf_valid_d   = buf_valid_q;

        if (consume) begin
            buf_valid_d = 1'b0;
        end

        if (redirect) begin
            // Redirect outranks stall, capture and HALT: flush buffer, retarget PC.
            pc_d        = redirect_pc;
            buf_valid_d = 1'b0;
            case (state_q)
                S_BUSY: begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d       = S_SQUASH;
                        squash_addr_d = pc_q;
                    end
                end
                S_SQUASH: begin
                    state_d = imem_ack ? S_IDLE : S_SQUASH;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end else begin
            case (state_q)
                S_IDLE: begin
                    // Only start a read when the buffer will be free by the time data returns.
                    if (can_accept) begin
                        state_d = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (imem_ack) begin
                        buf_instr_d = imem_data;
                        buf_pc2_d   = pc_next_seq;
                        buf_valid_d = 1'b1;
                        pc_d        = pc_next_seq;
                        state_d     = (imem_data[15:11] == HALT_OP) ? S_HALT : S_IDLE;
                    end
                end
                S_SQUASH: begin
                    if (imem_ack) begin
                        state_d = S_IDLE;
                    end
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= S_IDLE;
            pc_q          <= 16'h0000;
            squash_addr_q <= 16'h0000;
            buf_instr_q   <= 16'h0000;
            buf_pc2_q     <= 16'h0000;
            buf_valid_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            squash_addr_q <= squash_addr_d;
            buf_instr_q   <= buf_instr_d;
            buf_pc2_q     <= buf_pc2_d;
            buf_valid_q   <= buf_valid_d;
        end
    end

    // While squashing, the memory still owns the old address even though PC moved on.
    assign imem_req     = (state_q == S_BUSY) || (state_q == S_SQUASH);
    assign imem_addr    = (state_q == S_SQUASH) ? squash_addr_q : pc_q;
    assign instr_out    = buf_valid_q ? buf_instr_q : NOP_WORD;
    assign pc_plus2_out = buf_pc2_q;
    assign valid_out    = buf_valid_q;
    assign halted_out   = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: behavioural memory, expected-output
// scoreboard filled on acked fetches and drained when decode consumes.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [15:0] imem_data = 16'h0000;
    logic [15:0] instr_out;
    logic [15:0] pc_plus2_out;
    logic        valid_out;
    logic        halted_out;

    fetch_stage dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .redirect     (redirect),
        .redirect_pc  (redirect_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr_out    (instr_out),
        .pc_plus2_out (pc_plus2_out),
        .valid_out    (valid_out),
        .halted_out   (halted_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc2;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] addr_q[$];
    int          errors = 0;
    int          checks = 0;
    int          consumes = 0;
    bit          squashing = 1'b0;
    bit          pending = 1'b0;
    bit          halt_en = 1'b0;
    logic [15:0] halt_addr = 16'h0000;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (halt_en && a == halt_addr) return 16'h0000;
        return 16'h4000 + {1'b0, a[15:1]} + 16'd1;
    endfunction

    function automatic void clear_model();
        exp_q.delete();
        addr_q.delete();
        squashing = 1'b0;
        pending   = 1'b0;
        consumes  = 0;
    endfunction

    // One cycle of stimulus, applied at the falling edge for the next rising edge.
    task automatic tick(input bit ack_en, input bit do_stall, input bit do_redir,
                        input logic [15:0] rpc);
        exp_t e;
        @(negedge clk);
        stall       = do_stall;
        redirect    = do_redir;
        redirect_pc = rpc;
        imem_ack    = 1'b0;
        imem_data   = 16'hDEAD;
        if (valid_out && !do_stall) begin
            consumes++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL consume_unexpected: instr_out=%h pc_plus2_out=%h, required no valid output",
                         instr_out, pc_plus2_out);
            end else begin
                e = exp_q.pop_front();
                if (instr_out !== e.instr || pc_plus2_out !== e.pc2) begin
                    errors++;
                    $display("FAIL consume_data: got instr=%h pc2=%h, required instr=%h pc2=%h",
                             instr_out, pc_plus2_out, e.instr, e.pc2);
                end
            end
        end
        if (imem_req && !pending) addr_q.push_back(imem_addr);
        if (imem_req && ack_en) begin
            imem_ack  = 1'b1;
            imem_data = mem_word(imem_addr);
            if (!squashing && !do_redir) begin
                e.instr = imem_data;
                e.pc2   = imem_addr + 16'd2;
                exp_q.push_back(e);
            end
            squashing = 1'b0;
            pending   = 1'b0;
        end else begin
            pending = imem_req;
            if (imem_req && do_redir) squashing = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0000;
        imem_ack = 1'b0; imem_data = 16'h0000;
        halt_en = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic check_drained(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d outputs never delivered, required 0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || valid_out !== 1'b0 ||
                instr_out !== 16'h0800 || pc_plus2_out !== 16'h0000 || halted_out !== 1'b0) begin
                errors++;
                $display("FAIL reset_state: req=%b addr=%h valid=%b instr=%h pc2=%h halted=%b, required 0 0000 0 0800 0000 0",
                         imem_req, imem_addr, valid_out, instr_out, pc_plus2_out, halted_out);
            end
        end
        rst = 1'b1;
        clear_model();
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_first_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
    endtask

    task automatic test_sequential();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        @(posedge clk) #1;
        checks++;
        if (valid_out !== 1'b1 || instr_out !== 16'h4001 || pc_plus2_out !== 16'h0002) begin
            errors++;
            $display("FAIL seq_latency: valid=%b instr=%h pc2=%h, required 1 4001 0002",
                     valid_out, instr_out, pc_plus2_out);
        end
        for (int i = 0; i < 7; i++) tick(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (consumes != 4) begin
            errors++;
            $display("FAIL seq_throughput: %0d instructions in 8 cycles, required 4", consumes);
        end
        checks++;
        if (addr_q.size() != 4 || addr_q[0] !== 16'h0000 || addr_q[1] !== 16'h0002 ||
            addr_q[2] !== 16'h0004 || addr_q[3] !== 16'h0006) begin
            errors++;
            $display("FAIL seq_addrs: got %0d requests first=%h, required 0000,0002,0004,0006",
                     addr_q.size(), addr_q.size() > 0 ? addr_q[0] : 16'hxxxx);
        end
        check_drained("seq");
    endtask

    task automatic test_stall();
        do_reset();
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b1, 1'b0, 16'h0000);
            checks++;
            if (imem_req !== 1'b0 || valid_out !== 1'b1 || instr_out !== 16'h4001 ||
                pc_plus2_out !== 16'h0002) begin
                errors++;
                $display("FAIL stall_hold: req=%b valid=%b instr=%h pc2=%h, required 0 1 4001 0002",
                         imem_req, valid_out, instr_out, pc_plus2_out);
            end
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0002) begin
            errors++;
            $display("FAIL stall_resume: req=%b addr=%h, required 1 0002", imem_req, imem_addr);
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        check_drained("stall");
    endtask

    task automatic test_redirect_squash();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 16'h0010);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (valid_out !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL redir_ack_discard: valid=%b req=%b, required 0 0", valid_out, imem_req);
        end
        tick(1'b0, 1'b0, 1'b1, 16'h0100);
        for (int i = 0; i < 2; i++) begin
            tick(1'b0, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (imem_req !== 1'b1 || imem_addr !== 16'h0010 || valid_out !== 1'b0) begin
                errors++;
                $display("FAIL squash_hold: req=%b addr=%h valid=%b, required 1 0010 0",
                         imem_req, imem_addr, valid_out);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (valid_out !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL squash_discard: valid=%b req=%b, required 0 0", valid_out, imem_req);
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (addr_q.size() != 3 || addr_q[1] !== 16'h0010 || addr_q[2] !== 16'h0100) begin
            errors++;
            $display("FAIL squash_addrs: got %0d requests last=%h, required 0000,0010,0100",
                     addr_q.size(), addr_q.size() > 0 ? addr_q[addr_q.size()-1] : 16'hxxxx);
        end
        check_drained("squash");
    endtask

    task automatic test_halt();
        do_reset();
        halt_en   = 1'b1;
        halt_addr = 16'h0002;
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (halted_out !== 1'b1 || imem_req !== 1'b0 || valid_out !== 1'b1 || instr_out !== 16'h0000) begin
            errors++;
            $display("FAIL halt_enter: halted=%b req=%b valid=%b instr=%h, required 1 0 1 0000",
                     halted_out, imem_req, valid_out, instr_out);
        end
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, 1'b0, 1'b0, 16'h0000);
            checks++;
            if (halted_out !== 1'b1 || imem_req !== 1'b0 || valid_out !== 1'b0 || instr_out !== 16'h0800) begin
                errors++;
                $display("FAIL halt_stay: halted=%b req=%b valid=%b instr=%h, required 1 0 0 0800",
                         halted_out, imem_req, valid_out, instr_out);
            end
        end
        tick(1'b0, 1'b0, 1'b1, 16'h0040);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (halted_out !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL halt_leave: halted=%b req=%b, required 0 0", halted_out, imem_req);
        end
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (addr_q.size() == 0 || addr_q[addr_q.size()-1] !== 16'h0040) begin
            errors++;
            $display("FAIL halt_resume_addr: last request %h, required 0040",
                     addr_q.size() > 0 ? addr_q[addr_q.size()-1] : 16'hxxxx);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        halt_en = 1'b0;
        check_drained("halt");
    endtask

    task automatic test_wrap();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 16'hFFFE);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (addr_q.size() != 2 || addr_q[1] !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_req: %0d requests, last %h, required 0000,FFFE", addr_q.size(),
                     addr_q.size() > 0 ? addr_q[addr_q.size()-1] : 16'hxxxx);
        end
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap_next_addr: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
        check_drained("wrap");
    endtask

    task automatic test_async_reset();
        do_reset();
        tick(1'b1, 1'b0, 1'b1, 16'h0020);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0020) begin
            errors++;
            $display("FAIL areset_setup: req=%b addr=%h, required 1 0020", imem_req, imem_addr);
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || valid_out !== 1'b0 ||
            instr_out !== 16'h0800 || pc_plus2_out !== 16'h0000 || halted_out !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: req=%b addr=%h valid=%b instr=%h pc2=%h halted=%b, required 0 0000 0 0800 0000 0",
                     imem_req, imem_addr, valid_out, instr_out, pc_plus2_out, halted_out);
        end
        @(negedge clk);
        rst = 1'b1;
        clear_model();
        tick(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL areset_first_req: req=%b addr=%h, required 1 0000", imem_req, imem_addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_squash();
        test_halt();
        test_wrap();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units, required completion");
        $fatal(1, "timeout");
    end

endmodule
